spi_device_top: RTL and testbench
=================================

SPI_DEVICE_TOP -- requirements
Module: spi_device_top

Interface
REQ-001 Parameter RxDepth, default 16: depth of the received-byte FIFO; SHALL be a power of two, 2..64.
REQ-002 Parameter SyncStages, default 2: synchroniser flops on sck_i, cs_ni and mosi_i; SHALL be 2 or 3.
REQ-003 clk_i  input  1: the single clock for all logic.
REQ-004 rst_i  input  1: synchronous, active-high reset.
REQ-005 device_req_i  input  1: bus request, single-cycle.
REQ-006 device_addr_i  input  32: byte address; only bits [11:0] are decoded.
REQ-007 device_we_i  input  1: 1 for write, 0 for read.
REQ-008 device_be_i  input  4: byte enables; unused.
REQ-009 device_wdata_i  input  32: write data.
REQ-010 device_rvalid_o  output  1: response valid, one cycle after every request.
REQ-011 device_rdata_o  output  32: read data, valid with device_rvalid_o, 0 for writes.
REQ-012 sck_i  input  1: external SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-013 cs_ni  input  1: external chip select, active low.
REQ-014 mosi_i  input  1: serial data from the external host, MSB first.
REQ-015 miso_o  output  1: serial data to the external host, MSB first.
REQ-016 miso_oe_o  output  1: miso output enable; equals NOT synchronised cs_n.
REQ-017 rx_irq_o  output  1: level, 1 while the RX FIFO is non-empty.

Function
REQ-018 The block SHALL decode the register map: 0x0 RX_DATA (read pops the FIFO, rdata = {24'b0, byte}; empty gives 0 with no pop); 0x4 STATUS (read {29'b0, overflow, rx_full, rx_empty}; write with wdata[2]=1 clears overflow); 0x8 TX_DATA (write loads tx_data_q <= wdata[7:0]; read returns it).
REQ-019 Unmapped addresses SHALL read 0, ignore writes and still assert device_rvalid_o.
REQ-020 Edge detection SHALL operate on the synchronised signals only: sck_rise, sck_fall, cs_fall and cs_rise are single-cycle pulses.
REQ-021 A 3-bit bit counter and an 8-bit RX shift register SHALL clear whenever synchronised cs_n is high.
REQ-022 On sck_rise with cs_n low: rx_shift <= {rx_shift[6:0], mosi}, and the counter increments, wrapping 7 -> 0.
REQ-023 On the sck_rise that wraps the counter: the completed byte SHALL be pushed into the FIFO in the following cycle as a one-cycle push pulse.
REQ-024 On cs_fall: tx_shift <= tx_data_q.
REQ-025 On sck_fall with cs_n low: if counter == 0, tx_shift <= tx_data_q; otherwise tx_shift shifts left by one.
REQ-026 miso_o SHALL equal tx_shift[7], and 0 while cs_n is high.
REQ-027 Push to a full FIFO with no simultaneous pop: the byte SHALL be dropped and overflow set (sticky).
REQ-028 Simultaneous push and pop: both SHALL take effect; no overflow, even when full.
REQ-029 If an overflow clear and a new overflow occur in the same cycle, overflow SHALL remain 1.
REQ-030 cs_rise mid-byte: the partial byte SHALL be discarded and no push occurs.
REQ-031 Correct operation requires the clk_i frequency to be at least 8x the sck frequency; latency from the 8th sck rising edge at the pin to rx_empty=0 SHALL be at most SyncStages+3 cycles.

Reset
REQ-032 While rst_i is high: FIFO empty, overflow 0, tx_data_q 0x00, shifts and counter 0, synchronisers at sck=0, cs_n=1, mosi=0.
REQ-033 While rst_i is high: device_rvalid_o 0, device_rdata_o 0, miso_o 0, miso_oe_o 0, rx_irq_o 0.
REQ-034 Reset asserted mid-transfer SHALL abandon the byte; after release, reception resumes only after a fresh cs_fall.

Structure
REQ-035 A package spi_device_pkg SHALL hold the register offsets (RX_DATA, STATUS, TX_DATA) and the STATUS bit positions.
REQ-036 A single sub-module spi_device_shifter SHALL hold the synchronisers, edge detection, counter and shift registers.
REQ-037 The FIFO and the bus decode SHALL be in spi_device_top.

Verification
REQ-038 TX_DATA=0xA5; host sends 0x3C in one CS frame -> RX_DATA reads 0x3C, host receives 0xA5, then rx_empty=1.
REQ-039 Host sends 0x01..0x03 in one frame with TX_DATA=0x5A -> three FIFO entries in order; host receives 0x5A three times.
REQ-040 Host sends RxDepth+1 bytes with no reads -> rx_full=1, overflow=1, the first RxDepth bytes are intact.
REQ-041 Writing STATUS with 0x4 -> overflow clears.
REQ-042 cs_n deasserted after 5 bits, then byte 0x81 sent -> only 0x81 is queued.
REQ-043 Reset pulse after 4 bits -> all outputs at reset values; next full frame of 0x7E is received correctly.
REQ-044 A pop coincident with a push while full -> no overflow, depth unchanged.

Source files
------------

// File: rtl/spi_device_pkg.sv
// Shared definitions for the SPI device block.
// Holds the register offsets decoded from device_addr_i[11:0] and the
// bit positions of the STATUS register.
package spi_device_pkg;

    localparam logic [11:0] RegRxData = 12'h000;
    localparam logic [11:0] RegStatus = 12'h004;
    localparam logic [11:0] RegTxData = 12'h008;

    localparam int StatusEmptyBit    = 0;
    localparam int StatusFullBit     = 1;
    localparam int StatusOverflowBit = 2;

endpackage

// File: rtl/spi_device_if.sv
// Register bus between a host core and the SPI device.
// master: drives request, address, write enable, byte enables and write data.
// slave : returns a response valid one cycle after each request, plus read data.
interface spi_device_if;

    logic        device_req_i;
    logic [31:0] device_addr_i;
    logic        device_we_i;
    logic [3:0]  device_be_i;
    logic [31:0] device_wdata_i;
    logic        device_rvalid_o;
    logic [31:0] device_rdata_o;

    modport master (
        output device_req_i, device_addr_i, device_we_i, device_be_i, device_wdata_i,
        input  device_rvalid_o, device_rdata_o
    );

    modport slave (
        input  device_req_i, device_addr_i, device_we_i, device_be_i, device_wdata_i,
        output device_rvalid_o, device_rdata_o
    );

endinterface

// File: rtl/spi_device_shifter.sv
// SPI mode-0 serial engine: pin synchronisers, edge detection, bit counter,
// RX and TX shift registers.
// Ports:
//   clk_i, rst_i          system clock, synchronous active-high reset
//   sck_i, cs_ni, mosi_i  raw SPI pins from the external host
//   tx_data_i             byte presented to the host in every byte slot
//   push_o, push_data_o   one-cycle pulse with a completed received byte
//   miso_o, miso_oe_o     serial data to the host and its output enable
module spi_device_shifter #(
    parameter int SyncStages = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sck_i,
    input  logic       cs_ni,
    input  logic       mosi_i,
    input  logic [7:0] tx_data_i,
    output logic       push_o,
    output logic [7:0] push_data_o,
    output logic       miso_o,
    output logic       miso_oe_o
);

    logic [SyncStages-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic [SyncStages:0]   flush_q;
    logic                  sck_prev_q, cs_prev_q, armed_q;
    logic [2:0]            bit_cnt_q;
    logic [7:0]            rx_shift_q, tx_shift_q;

    logic sck_s, cs_s, mosi_s, edges_ok;
    logic sck_rise, sck_fall, cs_fall, cs_rise, rx_active;

    assign sck_s  = sck_sync_q[SyncStages-1];
    assign cs_s   = cs_sync_q[SyncStages-1];
    assign mosi_s = mosi_sync_q[SyncStages-1];

    // Right after reset the synchronisers hold their reset values, not pin
    // data. Edges are ignored until the chain has been refilled from the pins,
    // so a host still holding cs low across reset does not look like a new frame.
    assign edges_ok = flush_q[SyncStages];

    assign sck_rise = edges_ok &  sck_s & ~sck_prev_q;
    assign sck_fall = edges_ok & ~sck_s &  sck_prev_q;
    assign cs_fall  = edges_ok & ~cs_s  &  cs_prev_q;
    assign cs_rise  = edges_ok &  cs_s  & ~cs_prev_q;

    // armed_q is only set by a real cs falling edge, so a frame interrupted
    // by reset stays ignored until the host reselects the device.
    assign rx_active = armed_q & ~cs_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            flush_q     <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'h00;
            push_o      <= 1'b0;
            push_data_o <= 8'h00;
        end else begin
            sck_sync_q  <= {sck_sync_q[SyncStages-2:0], sck_i};
            cs_sync_q   <= {cs_sync_q[SyncStages-2:0], cs_ni};
            mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], mosi_i};
            flush_q     <= {flush_q[SyncStages-1:0], 1'b1};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
            push_o      <= 1'b0;

            if (cs_fall) begin
                armed_q <= 1'b1;
            end else if (cs_rise) begin
                armed_q <= 1'b0;
            end

            if (!rx_active) begin
                bit_cnt_q  <= 3'd0;
                rx_shift_q <= 8'h00;
            end else if (sck_rise) begin
                rx_shift_q <= {rx_shift_q[6:0], mosi_s};
                bit_cnt_q  <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    push_o      <= 1'b1;
                    push_data_o <= {rx_shift_q[6:0], mosi_s};
                end
            end

            // Counter at 0 on a falling edge means a byte boundary: reload.
            if (cs_fall) begin
                tx_shift_q <= tx_data_i;
            end else if (rx_active && sck_fall) begin
                if (bit_cnt_q == 3'd0) begin
                    tx_shift_q <= tx_data_i;
                end else begin
                    tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                end
            end
        end
    end

    assign miso_o    = tx_shift_q[7] & ~cs_s;
    assign miso_oe_o = ~cs_s;

endmodule

// File: rtl/spi_device_top.sv
// SPI device with a register bus: RX FIFO, STATUS and TX_DATA registers.
// Ports:
//   clk_i, rst_i   system clock, synchronous active-high reset
//   bus            register bus (slave side), rvalid one cycle after request
//   sck_i, cs_ni, mosi_i, miso_o, miso_oe_o   SPI mode-0 pins
//   rx_irq_o       high while the RX FIFO holds data
module spi_device_top
    import spi_device_pkg::*;
#(
    parameter int RxDepth    = 16,
    parameter int SyncStages = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    spi_device_if.slave  bus,
    input  logic         sck_i,
    input  logic         cs_ni,
    input  logic         mosi_i,
    output logic         miso_o,
    output logic         miso_oe_o,
    output logic         rx_irq_o
);

    localparam int PtrW = $clog2(RxDepth);
    localparam logic [PtrW:0] FullCount = RxDepth[PtrW:0];

    logic [7:0]      fifo_mem [RxDepth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            overflow_q;
    logic [7:0]      tx_data_q;
    logic            rvalid_q;
    logic [31:0]     rdata_q, rdata_d;

    logic       push;
    logic [7:0] push_data;
    logic       rx_empty, rx_full;
    logic [11:0] addr;
    logic       rd, wr, sel_rx, sel_status, sel_tx;
    logic       pop, do_push, ovf_set, ovf_clr;
    logic       unused_bus;

    spi_device_shifter #(.SyncStages(SyncStages)) u_shifter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sck_i       (sck_i),
        .cs_ni       (cs_ni),
        .mosi_i      (mosi_i),
        .tx_data_i   (tx_data_q),
        .push_o      (push),
        .push_data_o (push_data),
        .miso_o      (miso_o),
        .miso_oe_o   (miso_oe_o)
    );

    assign rx_empty   = (count_q == '0);
    assign rx_full    = (count_q == FullCount);
    assign addr       = bus.device_addr_i[11:0];
    assign rd         = bus.device_req_i & ~bus.device_we_i;
    assign wr         = bus.device_req_i &  bus.device_we_i;
    assign sel_rx     = (addr == RegRxData);
    assign sel_status = (addr == RegStatus);
    assign sel_tx     = (addr == RegTxData);

    // A pop frees a slot in the same cycle, so a push while full still lands.
    assign pop     = rd & sel_rx & ~rx_empty;
    assign do_push = push & (~rx_full | pop);
    assign ovf_set = push & rx_full & ~pop;
    assign ovf_clr = wr & sel_status & bus.device_wdata_i[StatusOverflowBit];

    assign unused_bus = ^{bus.device_be_i, bus.device_addr_i[31:12], bus.device_wdata_i[31:8]};

    always_comb begin
        rdata_d = 32'h0;
        if (rd) begin
            if (sel_rx && !rx_empty) begin
                rdata_d = {24'h0, fifo_mem[rd_ptr_q]};
            end else if (sel_status) begin
                rdata_d[StatusEmptyBit]    = rx_empty;
                rdata_d[StatusFullBit]     = rx_full;
                rdata_d[StatusOverflowBit] = overflow_q;
            end else if (sel_tx) begin
                rdata_d = {24'h0, tx_data_q};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) begin
            fifo_mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= 8'h00;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({do_push, pop})
                2'b10:   count_q <= count_q + (PtrW+1)'(1);
                2'b01:   count_q <= count_q - (PtrW+1)'(1);
                default: count_q <= count_q;
            endcase

            // A new overflow wins over a clear in the same cycle.
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end

            if (wr && sel_tx) begin
                tx_data_q <= bus.device_wdata_i[7:0];
            end

            rvalid_q <= bus.device_req_i;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.device_rvalid_o = rvalid_q;
    assign bus.device_rdata_o  = rdata_q;
    assign rx_irq_o            = ~rx_empty;

endmodule

// File: tb/tb_spi_device_top.sv
// Directed testbench for spi_device_top: drives the register bus and acts as
// an SPI mode-0 host, checking every result against hand-computed values.
module tb_spi_device_top;

    localparam int HALF    = 8;
    localparam int RxDepth = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic miso, miso_oe, rx_irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] rd;
    logic [7:0]  hrx, popped;

    spi_device_if bus();

    spi_device_top #(.RxDepth(RxDepth), .SyncStages(2)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .sck_i     (sck),
        .cs_ni     (cs_n),
        .mosi_i    (mosi),
        .miso_o    (miso),
        .miso_oe_o (miso_oe),
        .rx_irq_o  (rx_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.device_req_i  = 1'b1;
        bus.device_we_i   = 1'b0;
        bus.device_addr_i = a;
        @(negedge clk);
        bus.device_req_i  = 1'b0;
        chk("rvalid_read", {31'h0, bus.device_rvalid_o}, 32'h1);
        d = bus.device_rdata_o;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(tag, d, exp);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] w);
        bus.device_req_i   = 1'b1;
        bus.device_we_i    = 1'b1;
        bus.device_addr_i  = a;
        bus.device_wdata_i = w;
        @(negedge clk);
        bus.device_req_i   = 1'b0;
        bus.device_we_i    = 1'b0;
        chk("rvalid_write", {31'h0, bus.device_rvalid_o}, 32'h1);
        chk("rdata_write", bus.device_rdata_o, 32'h0);
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_end();
        mosi = 1'b0;
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    // Sends the top n bits of tx; optionally issues an RX_DATA read timed to
    // land on the same clock as the FIFO push of the final bit.
    task automatic spi_bits(input logic [7:0] tx, input int n, input bit pop_last,
                            output logic [7:0] rx, output logic [7:0] pdata);
        rx = 8'h00;
        pdata = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = tx[7-i];
            repeat (HALF) @(negedge clk);
            rx = {rx[6:0], miso};
            sck = 1'b1;
            if (pop_last && i == n - 1) begin
                repeat (3) @(negedge clk);
                bus.device_req_i  = 1'b1;
                bus.device_we_i   = 1'b0;
                bus.device_addr_i = 32'h0;
                @(negedge clk);
                bus.device_req_i  = 1'b0;
                pdata = bus.device_rdata_o[7:0];
                repeat (HALF - 4) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sck = 1'b0;
        end
    endtask

    initial begin
        bus.device_req_i   = 1'b0;
        bus.device_addr_i  = 32'h0;
        bus.device_we_i    = 1'b0;
        bus.device_be_i    = 4'hF;
        bus.device_wdata_i = 32'h0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_rvalid", {31'h0, bus.device_rvalid_o}, 32'h0);
        chk("rst_rdata", bus.device_rdata_o, 32'h0);
        chk("rst_miso", {31'h0, miso}, 32'h0);
        chk("rst_miso_oe", {31'h0, miso_oe}, 32'h0);
        chk("rst_irq", {31'h0, rx_irq}, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        read_chk("status_after_rst", 32'h4, 32'h1);
        read_chk("tx_after_rst", 32'h8, 32'h0);
        read_chk("rx_empty_read", 32'h0, 32'h0);

        // Single byte exchange
        bus_write(32'h8, 32'hA5);
        read_chk("tx_readback", 32'h8, 32'hA5);
        cs_begin();
        chk("miso_oe_active", {31'h0, miso_oe}, 32'h1);
        spi_bits(8'h3C, 8, 1'b0, hrx, popped);
        cs_end();
        chk("host_rx_a5", {24'h0, hrx}, 32'hA5);
        chk("irq_pending", {31'h0, rx_irq}, 32'h1);
        read_chk("rx_3c", 32'h0, 32'h3C);
        read_chk("status_empty_again", 32'h4, 32'h1);
        chk("irq_cleared", {31'h0, rx_irq}, 32'h0);

        // Three bytes in one frame
        bus_write(32'h8, 32'h5A);
        cs_begin();
        for (int b = 1; b <= 3; b++) begin
            spi_bits(8'(b), 8, 1'b0, hrx, popped);
            chk("host_rx_5a", {24'h0, hrx}, 32'h5A);
        end
        cs_end();
        read_chk("rx_01", 32'h0, 32'h01);
        read_chk("rx_02", 32'h0, 32'h02);
        read_chk("rx_03", 32'h0, 32'h03);

        // Unmapped addresses and partial decode
        read_chk("unmapped_10", 32'h10, 32'h0);
        read_chk("unmapped_0c", 32'hC, 32'h0);
        bus_write(32'hC, 32'hFF);
        read_chk("tx_unchanged", 32'h8, 32'h5A);
        read_chk("tx_alias_1008", 32'h1008, 32'h5A);

        // Overflow: RxDepth+1 bytes, no reads
        cs_begin();
        for (int b = 0; b <= RxDepth; b++) begin
            spi_bits(8'(8'h10 + b), 8, 1'b0, hrx, popped);
        end
        cs_end();
        read_chk("status_ovf_full", 32'h4, 32'h6);
        bus_write(32'h4, 32'h0);
        read_chk("status_no_clear_bit", 32'h4, 32'h6);
        bus_write(32'h4, 32'h4);
        read_chk("status_ovf_cleared", 32'h4, 32'h2);

        // Pop coincident with push while full
        cs_begin();
        spi_bits(8'hEE, 8, 1'b1, hrx, popped);
        cs_end();
        chk("coincident_pop", {24'h0, popped}, 32'h10);
        read_chk("status_full_no_ovf", 32'h4, 32'h2);
        for (int b = 1; b < RxDepth; b++) begin
            read_chk("drain", 32'h0, 32'(8'h10 + b));
        end
        read_chk("drain_last_ee", 32'h0, 32'hEE);
        read_chk("status_drained", 32'h4, 32'h1);

        // Partial byte discarded on cs deassert
        cs_begin();
        spi_bits(8'hB8, 5, 1'b0, hrx, popped);
        cs_end();
        read_chk("status_partial_none", 32'h4, 32'h1);
        cs_begin();
        spi_bits(8'h81, 8, 1'b0, hrx, popped);
        cs_end();
        read_chk("rx_81", 32'h0, 32'h81);
        read_chk("status_after_81", 32'h4, 32'h1);

        // Reset mid-transfer
        bus_write(32'h8, 32'h33);
        cs_begin();
        spi_bits(8'hF0, 4, 1'b0, hrx, popped);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_rvalid", {31'h0, bus.device_rvalid_o}, 32'h0);
        chk("mid_rst_rdata", bus.device_rdata_o, 32'h0);
        chk("mid_rst_miso", {31'h0, miso}, 32'h0);
        chk("mid_rst_miso_oe", {31'h0, miso_oe}, 32'h0);
        chk("mid_rst_irq", {31'h0, rx_irq}, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(8'hFF, 8, 1'b0, hrx, popped);
        read_chk("no_rx_without_cs_fall", 32'h4, 32'h1);
        read_chk("tx_cleared_by_rst", 32'h8, 32'h0);
        cs_end();
        cs_begin();
        spi_bits(8'h7E, 8, 1'b0, hrx, popped);
        cs_end();
        chk("host_rx_after_rst", {24'h0, hrx}, 32'h00);
        read_chk("rx_7e", 32'h0, 32'h7E);
        read_chk("status_final", 32'h4, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
